// File: rtl/inst_noc_pkg.sv
// Shared packet layout for the instruction path between the PE FIFOs and the NoC packetizer.
package inst_noc_pkg;
  localparam int PE_ID_W = 4;
  localparam int INST_W  = 14;
  localparam int PKT_W   = INST_W + PE_ID_W;

  // Field positions inside a packet: PE_node in the low nibble, ifmap(0)/filter(1) flag above it.
  localparam int PE_NODE_LSB = 0;
  localparam int TYPE_BIT    = 4;

  typedef logic [PKT_W-1:0] inst_pkt_t;

  function automatic logic [PE_ID_W-1:0] pkt_pe_node(input inst_pkt_t pkt);
    return pkt[PE_NODE_LSB +: PE_ID_W];
  endfunction
endpackage

// File: rtl/rr_priority_sel.sv
// Combinational round-robin pick: rotate the request vector so ptr sits at bit 0,
// take the lowest set bit, then map the offset back to an absolute port index.
module rr_priority_sel #(
  parameter int NUM_IN = 4,
  parameter int SRC_W  = 2
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SRC_W-1:0]  ptr,
  output logic [NUM_IN-1:0] gnt_onehot,
  output logic [SRC_W-1:0]  gnt_idx,
  output logic              any_gnt
);
  logic [2*NUM_IN-1:0] dbl;
  logic [NUM_IN-1:0]   rot;
  logic [SRC_W-1:0]    off;
  logic [SRC_W:0]      sum;

  always_comb begin
    dbl = {req, req};
    rot = dbl[ptr +: NUM_IN];
    any_gnt = |req;
    off = '0;
    // Descending scan so the lowest set bit of the rotated vector is the one that sticks.
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (rot[i]) off = SRC_W'(i);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (SRC_W+1)'(NUM_IN)) sum = sum - (SRC_W+1)'(NUM_IN);
    gnt_idx = sum[SRC_W-1:0];
    gnt_onehot = '0;
    if (any_gnt) gnt_onehot[gnt_idx] = 1'b1;
  end
endmodule

// File: rtl/inst_rr_arbiter.sv
// N:1 round-robin arbiter from the per-PE instruction FIFOs into one registered output stage.
// Handshake: a transfer happens on any edge where valid & ready are both 1, on both sides.
module inst_rr_arbiter
  import inst_noc_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int PKT_W  = inst_noc_pkg::PKT_W,
  parameter int SRC_W  = $clog2(NUM_IN),
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN*PKT_W-1:0] in_data,
  output logic [NUM_IN-1:0]       in_ready,
  output logic                    out_valid,
  output logic [PKT_W-1:0]        out_data,
  output logic [SRC_W-1:0]        out_src,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        pkt_cnt
);
  logic [SRC_W-1:0]  rr_ptr;
  logic [NUM_IN-1:0] gnt_onehot;
  logic [SRC_W-1:0]  gnt_idx;
  logic              any_gnt;
  logic              load_en;
  logic              grant;
  logic [PKT_W-1:0]  lanes [NUM_IN];

  for (genvar g = 0; g < NUM_IN; g++) begin : g_lane
    assign lanes[g] = in_data[g*PKT_W +: PKT_W];
  end

  rr_priority_sel #(
    .NUM_IN (NUM_IN),
    .SRC_W  (SRC_W)
  ) u_sel (
    .req        (in_valid),
    .ptr        (rr_ptr),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any_gnt    (any_gnt)
  );

  // The register may load when empty or when its current packet leaves this same edge.
  assign load_en  = ~rst & (~out_valid | out_ready);
  assign grant    = load_en & any_gnt;
  assign in_ready = load_en ? gnt_onehot : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      pkt_cnt   <= '0;
      rr_ptr    <= '0;
    end else begin
      if (out_valid && out_ready) pkt_cnt <= pkt_cnt + 1'b1;
      if (grant) begin
        out_data  <= lanes[gnt_idx];
        out_src   <= gnt_idx;
        out_valid <= 1'b1;
        rr_ptr    <= (gnt_idx == SRC_W'(NUM_IN - 1)) ? '0 : gnt_idx + 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_inst_rr_arbiter.sv
// Bench for inst_rr_arbiter: vector table, directed corner sequences, then random traffic
// against a queue-based reference model.
module tb_inst_rr_arbiter;
  localparam int N = 4;
  localparam int W = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  in_valid;
  logic [N*W-1:0] in_data;
  logic          out_ready;
  logic [N-1:0]  in_ready, in_ready4;
  logic          out_valid, out_valid4;
  logic [W-1:0]  out_data, out_data4;
  logic [1:0]    out_src, out_src4;
  logic [15:0]   pkt_cnt;
  logic [3:0]    pkt_cnt4;
  logic [W-1:0]  src_data [N];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int p = 0; p < N; p++) in_data[p*W +: W] = src_data[p];
  end

  inst_rr_arbiter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src), .out_ready(out_ready),
    .pkt_cnt(pkt_cnt)
  );

  inst_rr_arbiter #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready4),
    .out_valid(out_valid4), .out_data(out_data4), .out_src(out_src4), .out_ready(out_ready),
    .pkt_cnt(pkt_cnt4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input logic r, input logic [N-1:0] v, input logic ordy);
    rst = r;
    in_valid = v;
    out_ready = ordy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] tdata(input int p);
    return W'(18'h00A05 + p * 18'h11110);
  endfunction

  typedef struct {
    logic       r;
    logic [3:0] v;
    logic       ordy;
    logic [3:0] ir;
    logic       ov;
    logic [1:0] src;
    int         cnt;
    logic [1:0] ptr;
  } vec_t;

  vec_t tbl [16];

  // Reference model state for the random phase.
  int           m_ptr;
  logic         m_valid;
  int           m_src;
  int           m_cnt;
  logic [W-1:0] exp_q [$];

  initial begin
    for (int p = 0; p < N; p++) src_data[p] = tdata(p);
    drive(1'b1, 4'hF, 1'b1);

    // Reset, fairness with all ports valid, then sparse ports 1/3 with wrap.
    tbl[0]  = '{1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 0,  2'd0};
    tbl[1]  = '{1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 0,  2'd0};
    tbl[2]  = '{1'b0, 4'hF, 1'b1, 4'h1, 1'b0, 2'd0, 0,  2'd0};
    tbl[3]  = '{1'b0, 4'hF, 1'b1, 4'h2, 1'b1, 2'd0, 0,  2'd1};
    tbl[4]  = '{1'b0, 4'hF, 1'b1, 4'h4, 1'b1, 2'd1, 1,  2'd2};
    tbl[5]  = '{1'b0, 4'hF, 1'b1, 4'h8, 1'b1, 2'd2, 2,  2'd3};
    tbl[6]  = '{1'b0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd3, 3,  2'd0};
    tbl[7]  = '{1'b0, 4'hF, 1'b1, 4'h2, 1'b1, 2'd0, 4,  2'd1};
    tbl[8]  = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b1, 2'd1, 5,  2'd2};
    tbl[9]  = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd1, 6,  2'd2};
    tbl[10] = '{1'b0, 4'hA, 1'b1, 4'h8, 1'b0, 2'd1, 6,  2'd2};
    tbl[11] = '{1'b0, 4'hA, 1'b1, 4'h2, 1'b1, 2'd3, 6,  2'd0};
    tbl[12] = '{1'b0, 4'hA, 1'b1, 4'h8, 1'b1, 2'd1, 7,  2'd2};
    tbl[13] = '{1'b0, 4'hA, 1'b1, 4'h2, 1'b1, 2'd3, 8,  2'd0};
    tbl[14] = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b1, 2'd1, 9,  2'd2};
    tbl[15] = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd1, 10, 2'd2};

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].r, tbl[i].v, tbl[i].ordy);
      @(negedge clk);
      check($sformatf("tbl%0d in_ready", i), 32'(in_ready), 32'(tbl[i].ir));
      check($sformatf("tbl%0d out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      check($sformatf("tbl%0d out_src", i), 32'(out_src), 32'(tbl[i].src));
      check($sformatf("tbl%0d pkt_cnt", i), 32'(pkt_cnt), 32'(tbl[i].cnt));
      check($sformatf("tbl%0d pkt_cnt4", i), 32'(pkt_cnt4), 32'(tbl[i].cnt % 16));
      check($sformatf("tbl%0d rr_ptr", i), 32'(dut.rr_ptr), 32'(tbl[i].ptr));
      if (tbl[i].ov) check($sformatf("tbl%0d out_data", i), 32'(out_data), 32'(tdata(int'(tbl[i].src))));
      next_cycle();
    end

    // Backpressure: single packet on port 2 held while downstream stalls.
    src_data[2] = 18'h2A5C6;
    drive(1'b0, 4'h4, 1'b0);
    @(negedge clk);
    check("bp grant", 32'(in_ready), 32'h4);
    next_cycle();
    src_data[2] = 18'h11111;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("bp stall in_ready", 32'(in_ready), 32'h0);
      check("bp hold valid", 32'(out_valid), 32'h1);
      check("bp hold data", 32'(out_data), 32'h2A5C6);
      check("bp hold src", 32'(out_src), 32'h2);
      next_cycle();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp drain+load in_ready", 32'(in_ready), 32'h4);
    check("bp drain data", 32'(out_data), 32'h2A5C6);
    next_cycle();
    drive(1'b0, 4'h0, 1'b0);
    @(negedge clk);
    check("bp next data", 32'(out_data), 32'h11111);
    check("bp next valid", 32'(out_valid), 32'h1);
    check("bp cnt", 32'(pkt_cnt), 32'd11);
    next_cycle();

    // Reset while a stalled packet is held.
    drive(1'b1, 4'hF, 1'b0);
    @(negedge clk);
    check("mrst in_ready", 32'(in_ready), 32'h0);
    check("mrst cnt before", 32'(pkt_cnt), 32'd11);
    next_cycle();
    drive(1'b0, 4'h0, 1'b0);
    @(negedge clk);
    check("mrst out_valid", 32'(out_valid), 32'h0);
    check("mrst rr_ptr", 32'(dut.rr_ptr), 32'h0);
    check("mrst cnt", 32'(pkt_cnt), 32'h0);
    next_cycle();

    // 17 back-to-back transfers from port 0: the 4-bit counter wraps to 1.
    drive(1'b0, 4'h1, 1'b1);
    for (int k = 0; k < 17; k++) begin
      src_data[0] = W'($urandom);
      next_cycle();
    end
    in_valid = 4'h0;
    next_cycle();
    @(negedge clk);
    check("wrap cnt16", 32'(pkt_cnt), 32'd17);
    check("wrap cnt4", 32'(pkt_cnt4), 32'd1);
    check("wrap idle", 32'(out_valid), 32'h0);
    next_cycle();

    // Random traffic against the reference model.
    drive(1'b1, 4'h0, 1'b0);
    next_cycle();
    m_ptr = 0; m_valid = 1'b0; m_src = 0; m_cnt = 0; exp_q.delete();
    drive(1'b0, 4'h0, 1'b1);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      automatic int       winner = -1;
      automatic logic     load;
      automatic logic [N-1:0] exp_ir = '0;
      load = !rst && (!m_valid || out_ready);
      for (int k = 0; k < N; k++) begin
        automatic int p = (m_ptr + k) % N;
        if (winner < 0 && in_valid[p]) winner = p;
      end
      if (load && winner >= 0) exp_ir[winner] = 1'b1;
      @(negedge clk);
      check("rnd in_ready", 32'(in_ready), 32'(exp_ir));
      check("rnd out_valid", 32'(out_valid), 32'(m_valid));
      check("rnd pkt_cnt", 32'(pkt_cnt), 32'(m_cnt % 65536));
      check("rnd pkt_cnt4", 32'(pkt_cnt4), 32'(m_cnt % 16));
      if (m_valid) begin
        check("rnd out_src", 32'(out_src), 32'(m_src));
        check("rnd out_data", 32'(out_data), 32'(exp_q[0]));
      end
      @(posedge clk);
      if (rst) begin
        m_ptr = 0; m_valid = 1'b0; m_src = 0; m_cnt = 0; exp_q.delete();
      end else begin
        if (m_valid && out_ready) begin
          m_cnt++;
          void'(exp_q.pop_front());
        end
        if (exp_ir != '0) begin
          exp_q.push_back(src_data[winner]);
          m_src = winner;
          m_valid = 1'b1;
          m_ptr = (winner + 1) % N;
        end else if (out_ready) begin
          m_valid = 1'b0;
        end
      end
      #1;
      for (int p = 0; p < N; p++) begin
        if (exp_ir[p] || !in_valid[p]) begin
          in_valid[p] = ($urandom_range(0, 2) != 0);
          src_data[p] = W'($urandom);
        end else if ($urandom_range(0, 15) == 0) begin
          in_valid[p] = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 299) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
